decoder_rr_arbiter: RTL

//   Round-robin arbiter that shares the 2-to-4 decoder among four requesters.
//   It drives the decoder select inputs (EN, A1, A0) so that exactly one decoded

---
 rtl/decoder_rr_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing a 2-to-4 decoder among four requesters.
// Drives registered decoder selects and one-hot grant, with a dead gap and optional hold limit.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       EN,
  output logic       A1,
  output logic       A0,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       own_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             en_q;
  logic [3:0]       gnt_q;
  logic             timeout_q;

  logic             pick_vld_c;
  logic [1:0]       pick_idx_c;
  logic             expire_c;
  logic             own_req_c;

  // First requester at or after ptr; descending loop lets the nearest one win.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = ptr_q + 2'(k);
      end
    end
  end

  assign expire_c  = HOLD_EN && (hold_cnt_q == HOLD_LAST);
  assign own_req_c = req[own_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      own_q      <= 2'd0;
      hold_cnt_q <= '0;
      en_q       <= 1'b0;
      gnt_q      <= 4'b0000;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld_c) begin
            state_q    <= GRANT;
            own_q      <= pick_idx_c;
            hold_cnt_q <= '0;
            en_q       <= 1'b1;
            gnt_q      <= 4'b0001 << pick_idx_c;
          end
        end
        GRANT: begin
          if (!own_req_c || expire_c) begin
            // own_q is kept so the decoder selects stay quiet during the gap.
            state_q   <= IDLE;
            ptr_q     <= own_q + 2'd1;
            en_q      <= 1'b0;
            gnt_q     <= 4'b0000;
            timeout_q <= own_req_c && expire_c;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EN       = en_q;
  assign {A1, A0} = own_q;
  assign gnt      = gnt_q;
  assign busy     = en_q;
  assign timeout  = timeout_q;

endmodule
